// File: rtl/temp_display_sched.sv
// Round-robin temperature readout sequencer. Grants one sensor at a time,
// converts its 12-bit sample to BCD with a serial double-dabble engine, and
// parks the result in a per-sensor shadow register. Shadow values move to the
// display-facing registers only on frame_start, so renderers never tear.
module temp_display_sched #(
  parameter int NUM_SENSORS = 2,
  parameter int MAX_DISPLAY = 999
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SENSORS-1:0]    sample_valid,
  input  logic [12*NUM_SENSORS-1:0] sample_data,
  output logic [NUM_SENSORS-1:0]    sample_ack,
  input  logic                      frame_start,
  output logic [12*NUM_SENSORS-1:0] disp_bcd,
  output logic [NUM_SENSORS-1:0]    disp_overflow,
  output logic                      busy
);

  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  // Clamp value already in BCD form: hundreds/tens/ones.
  localparam logic [11:0] MAX_BCD = {4'(MAX_DISPLAY / 100),
                                     4'((MAX_DISPLAY / 10) % 10),
                                     4'(MAX_DISPLAY % 10)};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_STORE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [11:0]      raw_q, raw_d;      // captured binary value, kept for the clamp test
  logic [27:0]      dd_q, dd_d;        // {bcd16, bin12} double-dabble shift register
  logic [3:0]       cnt_q, cnt_d;      // remaining iterations

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  int               cand;

  logic [11:0]      store_bcd;
  logic             store_ovf;

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
  function automatic logic [27:0] dd_step(input logic [27:0] v);
    logic [27:0] t;
    t = v;
    for (int n = 0; n < 4; n++) begin
      if (t[12+4*n +: 4] >= 4'd5) begin
        t[12+4*n +: 4] = t[12+4*n +: 4] + 4'd3;
      end
    end
    return {t[26:0], 1'b0};
  endfunction

  // Round-robin search starting just past the last granted sensor.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_SENSORS; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_SENSORS;
      if (!grant_found && sample_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic and the combinational ack pulse issued in the grant cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    raw_d        = raw_q;
    dd_d         = dd_q;
    cnt_d        = cnt_q;
    sample_ack   = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          sample_ack[grant_idx] = reset_n;
          raw_d        = sample_data[12*int'(grant_idx) +: 12];
          dd_d         = {16'd0, sample_data[12*int'(grant_idx) +: 12]};
          cnt_d        = 4'd12;
          last_grant_d = grant_idx;
          state_d      = S_CONVERT;
        end
      end
      S_CONVERT: begin
        dd_d  = dd_step(dd_q);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_SENSORS - 1);
      raw_q        <= '0;
      dd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      raw_q        <= raw_d;
      dd_q         <= dd_d;
      cnt_q        <= cnt_d;
    end
  end

  // Value written to the shadow of the granted sensor during STORE.
  always_comb begin
    store_ovf = (int'(raw_q) > MAX_DISPLAY);
    store_bcd = store_ovf ? MAX_BCD : dd_q[23:12];
  end

  assign busy = (state_q != S_IDLE);

  generate
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
      logic [11:0] shadow_bcd_q;
      logic        shadow_ovf_q;
      logic [11:0] disp_bcd_q;
      logic        disp_ovf_q;

      // Shadow written in STORE; display copy taken from the old shadow on frame_start.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          shadow_bcd_q <= '0;
          shadow_ovf_q <= 1'b0;
          disp_bcd_q   <= '0;
          disp_ovf_q   <= 1'b0;
        end else begin
          if (state_q == S_STORE && last_grant_q == IDX_W'(gi)) begin
            shadow_bcd_q <= store_bcd;
            shadow_ovf_q <= store_ovf;
          end
          if (frame_start) begin
            disp_bcd_q <= shadow_bcd_q;
            disp_ovf_q <= shadow_ovf_q;
          end
        end
      end

      assign disp_bcd[12*gi +: 12] = disp_bcd_q;
      assign disp_overflow[gi]     = disp_ovf_q;
    end
  endgenerate

endmodule

// File: tb/tb_temp_display_sched.sv
// Bench for temp_display_sched: table of single conversions, directed
// multi-cycle corner sequences, and a randomized run against a cycle-level
// reference model built from the scheduling rules.
module tb_temp_display_sched;
  localparam int N = 2;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    sample_valid;
  logic [12*N-1:0] sample_data;
  logic [N-1:0]    sample_ack;
  logic            frame_start;
  logic [12*N-1:0] disp_bcd;
  logic [N-1:0]    disp_overflow;
  logic            busy;

  int n_checks = 0;
  int n_err    = 0;

  temp_display_sched #(.NUM_SENSORS(N), .MAX_DISPLAY(999)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_ack    (sample_ack),
    .frame_start   (frame_start),
    .disp_bcd      (disp_bcd),
    .disp_overflow (disp_overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  typedef struct {
    int          s;
    int          d;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = '0;
    sample_data  = '0;
    frame_start  = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    int c;
    c = (v > 999) ? 999 : v;
    return 12'(((c / 100) << 8) | (((c / 10) % 10) << 4) | (c % 10));
  endfunction

  // Request one conversion on sensor s, wait for it, then commit with frame_start.
  task automatic convert_one(input int s, input int d, output int waited, output int busy_cnt);
    sample_valid[s] = 1'b1;
    sample_data[12*s +: 12] = 12'(d);
    #1;
    waited = 0;
    while (sample_ack == '0 && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    chk("ack_onehot", 32'(sample_ack), 32'(1 << s));
    tick();
    sample_valid[s] = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cnt++;
      tick();
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Reference model state for the randomized run.
  int          m_rem;
  int          m_ptr;
  int          m_g;
  int          m_cap;
  logic [11:0] m_shadow [N];
  logic        m_sovf   [N];
  logic [11:0] m_disp   [N];
  logic        m_dovf   [N];

  initial begin
    int waited, bc, g;
    int ack_cyc[$];
    int ack_who[$];
    logic [N-1:0]    exp_ack;
    logic [12*N-1:0] exp_disp;
    logic [N-1:0]    exp_dovf;

    vecs[0] = '{0, 75,   12'h075, 1'b0};
    vecs[1] = '{0, 0,    12'h000, 1'b0};
    vecs[2] = '{0, 999,  12'h999, 1'b0};
    vecs[3] = '{1, 4095, 12'h999, 1'b1};
    vecs[4] = '{1, 1000, 12'h999, 1'b1};
    vecs[5] = '{0, 500,  12'h500, 1'b0};
    vecs[6] = '{1, 123,  12'h123, 1'b0};
    vecs[7] = '{1, 998,  12'h998, 1'b0};

    // Reset state.
    do_reset();
    #1;
    chk("reset_ack", 32'(sample_ack), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_disp", 32'(disp_bcd), 0);
    chk("reset_ovf", 32'(disp_overflow), 0);

    // Table of single conversions.
    for (int i = 0; i < 8; i++) begin
      convert_one(vecs[i].s, vecs[i].d, waited, bc);
      $display("vec %0d: sensor %0d data %0d -> bcd %03h ovf %0b", i, vecs[i].s, vecs[i].d,
               disp_bcd[12*vecs[i].s +: 12], disp_overflow[vecs[i].s]);
      chk("ack_latency", 32'(waited), 0);
      chk("busy_cycles", 32'(bc), 13);
      chk("vec_bcd", 32'(disp_bcd[12*vecs[i].s +: 12]), 32'(vecs[i].exp_bcd));
      chk("vec_ovf", 32'(disp_overflow[vecs[i].s]), 32'(vecs[i].exp_ovf));
    end

    // Both sensors requesting continuously from reset: strict alternation.
    do_reset();
    sample_valid = 2'b11;
    sample_data  = {12'd321, 12'd654};
    for (int c = 0; c < 60; c++) begin
      #1;
      if (sample_ack != '0) begin
        ack_cyc.push_back(c);
        ack_who.push_back(int'(sample_ack));
      end
      tick();
    end
    sample_valid = '0;
    chk("rr_count", 32'(ack_cyc.size()), 5);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      $display("rr ack %0d at cycle %0d mask %0b", i, ack_cyc[i], ack_who[i]);
      chk("rr_who", 32'(ack_who[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) chk("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 14);
    end
    repeat (20) tick();

    // frame_start coincident with STORE commits the old shadow.
    do_reset();
    convert_one(0, 17, waited, bc);
    chk("pre_disp", 32'(disp_bcd[11:0]), 32'h017);
    sample_valid[0] = 1'b1;
    sample_data[11:0] = 12'd42;
    #1;
    chk("coinc_ack", 32'(sample_ack), 1);
    tick();
    sample_valid[0] = 1'b0;
    repeat (12) tick();
    frame_start = 1'b1;
    chk("coinc_busy_store", 32'(busy), 1);
    tick();
    frame_start = 1'b0;
    $display("coincident commit: disp %03h", disp_bcd[11:0]);
    chk("coinc_old", 32'(disp_bcd[11:0]), 32'h017);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("coinc_new", 32'(disp_bcd[11:0]), 32'h042);

    // Reset in the 6th CONVERT cycle abandons the conversion.
    do_reset();
    sample_valid[0] = 1'b1;
    sample_data[11:0] = 12'd300;
    #1;
    chk("abort_ack", 32'(sample_ack), 1);
    tick();
    sample_valid[0] = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack0", 32'(sample_ack), 0);
    chk("abort_disp", 32'(disp_bcd), 0);
    reset_n = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("abort_noshadow", 32'(disp_bcd), 0);
    sample_valid = 2'b11;
    #1;
    chk("abort_restart_s0", 32'(sample_ack), 1);
    tick();
    sample_valid = '0;
    repeat (16) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("abort_redo_s0", 32'(disp_bcd[11:0]), 32'h300);
    chk("abort_redo_s1", 32'(disp_bcd[23:12]), 0);

    // Randomized run against the reference model.
    do_reset();
    m_rem = 0;
    m_ptr = N - 1;
    m_g   = 0;
    m_cap = 0;
    for (int s = 0; s < N; s++) begin
      m_shadow[s] = '0; m_sovf[s] = 1'b0; m_disp[s] = '0; m_dovf[s] = 1'b0;
    end
    for (int c = 0; c < 1200; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!sample_valid[s]) begin
          if ($urandom_range(3) == 0) sample_valid[s] = 1'b1;
        end else if ($urandom_range(15) == 0) begin
          sample_valid[s] = 1'b0;
        end
        if ($urandom_range(1) == 0) begin
          case ($urandom_range(3))
            0: sample_data[12*s +: 12] = 12'($urandom_range(997, 1001));
            default: sample_data[12*s +: 12] = 12'($urandom_range(4095));
          endcase
        end
      end
      frame_start = ($urandom_range(5) == 0);
      #1;
      exp_ack = '0;
      g = -1;
      if (m_rem == 0) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && sample_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g >= 0) exp_ack[g] = 1'b1;
      end
      for (int s = 0; s < N; s++) begin
        exp_disp[12*s +: 12] = m_disp[s];
        exp_dovf[s] = m_dovf[s];
      end
      chk("rnd_ack", 32'(sample_ack), 32'(exp_ack));
      chk("rnd_busy", 32'(busy), (m_rem != 0) ? 32'd1 : 32'd0);
      chk("rnd_disp", 32'(disp_bcd), 32'(exp_disp));
      chk("rnd_ovf", 32'(disp_overflow), 32'(exp_dovf));
      // Model update for this edge: commit first (old shadow), then scheduling.
      if (frame_start) begin
        for (int s = 0; s < N; s++) begin
          m_disp[s] = m_shadow[s];
          m_dovf[s] = m_sovf[s];
        end
      end
      if (m_rem > 0) begin
        if (m_rem == 1) begin
          m_shadow[m_g] = to_bcd(m_cap);
          m_sovf[m_g]   = (m_cap > 999);
        end
        m_rem--;
      end else if (g >= 0) begin
        m_cap = int'(sample_data[12*g +: 12]);
        m_g   = g;
        m_ptr = g;
        m_rem = 13;
        $display("rnd grant cycle %0d sensor %0d data %0d", c, g, m_cap);
      end
      tick();
      if (g >= 0 && $urandom_range(3) != 0) sample_valid[g] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/temp_display_sched.md
Name: temp_display_sched

Overview:
Round-robin scheduler and sequencer that feeds the on-screen temperature readouts. It arbitrates between NUM_SENSORS 12-bit temperature sources and converts one granted sample at a time to 3-digit BCD with a serial double-dabble engine. Results sit in shadow registers and are committed to the display-facing registers only on a frame-start pulse, so the font/digit renderers never tear mid-frame.

Parameters:
NUM_SENSORS, 2, number of temperature sources/readouts (1..8)
MAX_DISPLAY, 999, largest value representable on 3 digits; larger inputs clamp

Ports:
clk  input  1  system/pixel clock
reset_n  input  1  synchronous active-low reset
sample_valid  input  NUM_SENSORS  per-sensor new-sample request; level, held until acked
sample_data  input  12*NUM_SENSORS  binary temperature, sensor i at [12i+11:12i]
sample_ack  output  NUM_SENSORS  one-hot, 1-cycle pulse: sample captured
frame_start  input  1  1-cycle pulse at start of vertical blanking
disp_bcd  output  12*NUM_SENSORS  committed BCD per sensor, hundreds/tens/ones in [11:8]/[7:4]/[3:0]
disp_overflow  output  NUM_SENSORS  committed flag: sample exceeded MAX_DISPLAY
busy  output  1  high while not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset_n synchronous, active-low.
- Reset values: sample_ack=0, disp_bcd=0, disp_overflow=0, shadow regs=0, busy=0, state=IDLE, last_grant=NUM_SENSORS-1 (sensor 0 has first priority).
- FSM states are IDLE, CONVERT and STORE.
- IDLE: when any sample_valid is set, grant the first valid sensor searching from last_grant+1 with wrap-around. In the same cycle, pulse sample_ack[g], capture sample_data[g], update last_grant=g, load the shift counter=12, clear the BCD accumulator, and go to CONVERT. With no valid sensor, stay in IDLE.
- CONVERT: one double-dabble iteration per cycle. Each BCD nibble >=5 gets +3, then the {bcd16, bin12} register shifts left by 1. The BCD accumulator is 16 bits wide (thousands included) so that 4095 converts exactly. After 12 iterations, go to STORE.
- STORE (1 cycle): if the captured binary value > MAX_DISPLAY, shadow_bcd[g]=BCD(MAX_DISPLAY) and shadow_ovf[g]=1. Otherwise shadow_bcd[g]=low 12 BCD bits and shadow_ovf[g]=0. Then return to IDLE.
- Latency: ack in cycle T, CONVERT in T+1..T+12, STORE in T+13, shadow updated at the T+13 edge. The next grant is possible at T+14. Throughput is 1 sample per 14 cycles.
- Commit: on frame_start, disp_bcd/disp_overflow <= shadow for all sensors. Outputs change only on that edge.
- Simultaneous frame_start and STORE: the commit takes the pre-STORE shadow value. The new value appears at the following frame_start.
- frame_start during IDLE/CONVERT has no effect on the FSM.
- sample_valid deasserted by a source before ack: no grant. sample_data is sampled only in the ack cycle; later changes are ignored.
- A sensor still holding valid after its ack is rearbitrated fairly: the round-robin pointer has already moved past it.
- Reset asserted mid-CONVERT: the conversion is abandoned, no shadow write, all outputs return to reset values next edge.
- busy=1 in CONVERT and STORE, 0 in IDLE. It is a registered state decode.
- Non-numeric font codes (e.g. degree symbol) are not generated here.

Test Plan:
- Reset, then sensor0 valid with data=12'd75, one frame_start after 20 cycles -> ack[0] on the first cycle, busy high for 13 cycles, disp_bcd[11:0]=12'h075 after frame_start, disp_overflow[0]=0.
- data=12'd0, then 12'd999 on sensor0 -> 12'h000 and then 12'h999 after the respective commits, no overflow.
- data=12'd4095 on sensor1 -> disp_bcd[23:12]=12'h999, disp_overflow[1]=1.
- Both sensors valid continuously from reset -> acks alternate 0,1,0,1 at 14-cycle spacing, and neither sensor is granted twice in a row.
- frame_start coincident with STORE for sensor0 (data 12'd42, previous shadow 12'h017) -> disp shows 12'h017, then 12'h042 after the next frame_start.
- reset_n low during cycle 6 of CONVERT -> no shadow write, ack/busy/disp all 0. After release, a grant restarts at sensor0.
